// File: rtl/tracker_pkg.sv
// Shared definitions for the tracker positioner and the command FSMs that drive it.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tracker_pkg;

    localparam int ANGLE_W = 5;

    localparam int DEF_STEP_DIV       = 4;
    localparam int DEF_STEPS_PER_UNIT = 8;
    localparam int DEF_REFL_SETTLE    = 16;

    // Positioner FSM encoding; the command FSMs decode these values, so keep them fixed.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STEP_HI = 3'd2,
        ST_STEP_LO = 3'd3,
        ST_REFL    = 3'd4,
        ST_SETTLE  = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

endpackage

// File: rtl/step_timer.sv
// Loadable down-counter that times one step half-period of STEP_DIV cycles.
// Latency: tick is high in the STEP_DIV-th cycle after the load edge.
// Backpressure: none; load restarts the count unconditionally.
module step_timer #(
    parameter int STEP_DIV = 4
) (
    input  logic clk,
    input  logic res,
    input  logic i_load,
    output logic o_tick
);

    localparam int W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    logic [W-1:0] r_cnt;

    // Count down from STEP_DIV-1 after a load, then park at zero.
    always_ff @(posedge clk) begin
        if (!res) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= W'(STEP_DIV - 1);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_tick = (r_cnt == '0);

endmodule

// File: rtl/tracker_positioner.sv
// Executes one pointing command: steps the motor to the target angle, then sets the reflector.
// Latency: 3 cycles for a zero move; otherwise + dist*STEPS_PER_UNIT*2*STEP_DIV (+REFL_SETTLE on reflector change).
// Backpressure: cmd_rdy only in IDLE; cmd_valid elsewhere is dropped. Macro TRACKER_SOFT_LIMIT_EN enables end-stop clamping.
module tracker_positioner
    import tracker_pkg::*;
#(
    parameter int STEP_DIV       = DEF_STEP_DIV,
    parameter int STEPS_PER_UNIT = DEF_STEPS_PER_UNIT,
    parameter int REFL_SETTLE    = DEF_REFL_SETTLE
`ifdef TRACKER_SOFT_LIMIT_EN
    ,
    parameter logic [ANGLE_W-1:0] ANGLE_MAX = 5'd30
`endif
) (
    input  logic               clk,
    input  logic               res,
    input  logic [ANGLE_W-1:0] angle,
    input  logic               refl,
    input  logic               cmd_valid,
    output logic               cmd_rdy,
    output logic               step,
    output logic               dir,
    output logic               refl_out,
    output logic [ANGLE_W-1:0] pos,
    output logic               busy,
    output logic               done,
    output logic               limit
);

    localparam int CNT_W     = ANGLE_W + $clog2(STEPS_PER_UNIT) + 1;
    localparam int SUB_W     = (STEPS_PER_UNIT > 1) ? $clog2(STEPS_PER_UNIT) : 1;
    localparam int SET_W     = (REFL_SETTLE > 1) ? $clog2(REFL_SETTLE) : 1;
    localparam int SETTLE_LD = (REFL_SETTLE > 0) ? REFL_SETTLE - 1 : 0;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ANGLE_W-1:0] r_tgt;
    logic               r_tgt_refl;
    logic [ANGLE_W-1:0] r_pos;
    logic               r_dir;
    logic               r_step;
    logic               r_refl_out;
    logic [CNT_W-1:0]   r_steps;
    logic [SUB_W-1:0]   r_sub;
    logic [SET_W-1:0]   r_settle;
    logic               w_tmr_load;
    logic               w_tick;
    logic [ANGLE_W:0]   w_dist;
    logic [ANGLE_W:0]   w_abs;
    logic [CNT_W-1:0]   w_load;
    logic               w_refl_chg;

    // Signed 6-bit distance to target; the magnitude scaled by steps per unit seeds the step counter.
    assign w_dist     = {1'b0, r_tgt} - {1'b0, r_pos};
    assign w_abs      = w_dist[ANGLE_W] ? ((ANGLE_W+1)'(0) - w_dist) : w_dist;
    assign w_load     = CNT_W'(w_abs) * CNT_W'(STEPS_PER_UNIT);
    assign w_refl_chg = (r_tgt_refl != r_refl_out);

    step_timer #(
        .STEP_DIV(STEP_DIV)
    ) u_step_timer (
        .clk   (clk),
        .res   (res),
        .i_load(w_tmr_load),
        .o_tick(w_tick)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!res) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; the half-period timer is reloaded on every step phase change.
    always_comb begin
        w_state_nxt = r_state;
        w_tmr_load  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) w_state_nxt = ST_SETUP;
            end
            ST_SETUP: begin
                w_tmr_load  = 1'b1;
                w_state_nxt = (w_abs == '0) ? ST_REFL : ST_STEP_HI;
            end
            ST_STEP_HI: begin
                if (w_tick) begin
                    w_tmr_load  = 1'b1;
                    w_state_nxt = ST_STEP_LO;
                end
            end
            ST_STEP_LO: begin
                if (w_tick) begin
                    w_tmr_load  = 1'b1;
                    w_state_nxt = (r_steps == CNT_W'(1)) ? ST_REFL : ST_STEP_HI;
                end
            end
            ST_REFL: begin
                w_state_nxt = (w_refl_chg && (REFL_SETTLE > 0)) ? ST_SETTLE : ST_DONE;
            end
            ST_SETTLE: begin
                if (r_settle == '0) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath: command latch, step/position tracking, reflector drive and settle count.
    // Step is a registered image of STEP_HI, so dir (set in SETUP) leads the first rise by a cycle
    // and the falling edge of each step lands in the first STEP_LO cycle, where pos advances.
    always_ff @(posedge clk) begin
        if (!res) begin
            r_tgt      <= '0;
            r_tgt_refl <= 1'b0;
            r_pos      <= '0;
            r_dir      <= 1'b0;
            r_step     <= 1'b0;
            r_refl_out <= 1'b0;
            r_steps    <= '0;
            r_sub      <= '0;
            r_settle   <= '0;
        end else begin
            r_step <= (r_state == ST_STEP_HI);
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_tgt_refl <= refl;
`ifdef TRACKER_SOFT_LIMIT_EN
                        r_tgt      <= (angle > ANGLE_MAX) ? ANGLE_MAX : angle;
`else
                        r_tgt      <= angle;
`endif
                    end
                end
                ST_SETUP: begin
                    r_dir   <= (r_tgt > r_pos);
                    r_steps <= w_load;
                    r_sub   <= '0;
                end
                ST_STEP_LO: begin
                    if (r_step) begin
                        if (r_sub == SUB_W'(STEPS_PER_UNIT - 1)) begin
                            r_sub <= '0;
                            r_pos <= r_dir ? (r_pos + ANGLE_W'(1)) : (r_pos - ANGLE_W'(1));
                        end else begin
                            r_sub <= r_sub + SUB_W'(1);
                        end
                    end
                    if (w_tick) r_steps <= r_steps - CNT_W'(1);
                end
                ST_REFL: begin
                    if (w_refl_chg) r_refl_out <= r_tgt_refl;
                    r_settle <= SET_W'(SETTLE_LD);
                end
                ST_SETTLE: begin
                    if (r_settle != '0) r_settle <= r_settle - SET_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

`ifdef TRACKER_SOFT_LIMIT_EN
    logic r_limit;

    // Clamp flag: captured at acceptance, so the next accepted command clears it.
    always_ff @(posedge clk) begin
        if (!res) begin
            r_limit <= 1'b0;
        end else if ((r_state == ST_IDLE) && cmd_valid) begin
            r_limit <= (angle > ANGLE_MAX);
        end
    end

    assign limit = r_limit;
`else
    assign limit = 1'b0;
`endif

    assign cmd_rdy  = (r_state == ST_IDLE);
    assign busy     = (r_state != ST_IDLE);
    assign done     = (r_state == ST_DONE);
    assign step     = r_step;
    assign dir      = r_dir;
    assign refl_out = r_refl_out;
    assign pos      = r_pos;

endmodule

// File: tb/tb_tracker_positioner.sv
// Randomized command stream against a command-level model of the positioner.
// Latency: n/a (testbench).
// Backpressure: commands are only driven while cmd_rdy is high, except deliberate mid-move pokes.
module tb_tracker_positioner;

    localparam int D    = 2;
    localparam int SPU  = 2;
    localparam int S    = 4;
    localparam int AMAX = 30;

    logic       clk = 1'b0;
    logic       res;
    logic [4:0] angle;
    logic       refl;
    logic       cmd_valid;
    logic       cmd_rdy;
    logic       step;
    logic       dir;
    logic       refl_out;
    logic [4:0] pos;
    logic       busy;
    logic       done;
    logic       limit;

    int n_checks = 0;
    int n_fail   = 0;

    // Command-level model state.
    int m_pos  = 0;
    int m_refl = 0;

    always #5 clk = ~clk;

    tracker_positioner #(
        .STEP_DIV      (D),
        .STEPS_PER_UNIT(SPU),
        .REFL_SETTLE   (S)
    ) dut (
        .clk      (clk),
        .res      (res),
        .angle    (angle),
        .refl     (refl),
        .cmd_valid(cmd_valid),
        .cmd_rdy  (cmd_rdy),
        .step     (step),
        .dir      (dir),
        .refl_out (refl_out),
        .pos      (pos),
        .busy     (busy),
        .done     (done),
        .limit    (limit)
    );

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Issue one command at the current negedge and follow it to completion.
    task automatic run_cmd(input int a, input int r, input bit poke);
        int  tgt, start, exp_lim, exp_busy, sgn, budget;
        int  busy_cyc, rises, falls, hi_len, lo_len, prev_pos;
        int  bad_w, bad_dir, bad_pos;
        bit  prev_step, in_low, got_done;

        tgt     = a;
        exp_lim = 0;
`ifdef TRACKER_SOFT_LIMIT_EN
        if (tgt > AMAX) tgt = AMAX;
        exp_lim = (a > AMAX) ? 1 : 0;
`endif
        start    = m_pos;
        sgn      = (tgt > start) ? 1 : -1;
        exp_busy = 1 + iabs(tgt - start) * SPU * 2 * D + 1 + ((r != m_refl) ? S : 0) + 1;

        budget = 0;
        while (!cmd_rdy && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        check_val("rdy_before_cmd", int'(cmd_rdy), 1);
        angle     = 5'(a);
        refl      = r[0];
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check_val("busy_after_accept", int'(busy), 1);
        check_val("rdy_after_accept", int'(cmd_rdy), 0);

        busy_cyc = 0; rises = 0; falls = 0; hi_len = 0; lo_len = 0;
        bad_w = 0; bad_dir = 0; bad_pos = 0;
        prev_step = 1'b0; in_low = 1'b0; got_done = 1'b0; prev_pos = start;
        budget = 2000;
        while (!got_done && budget > 0) begin
            if (busy) busy_cyc++;
            if (step && !prev_step) begin
                rises++;
                if (int'(dir) != ((tgt > start) ? 1 : 0)) bad_dir++;
                if (in_low && lo_len != D) bad_w++;
                hi_len = 1;
                in_low = 1'b0;
            end else if (step) begin
                hi_len++;
            end else if (prev_step) begin
                falls++;
                if (hi_len != D) bad_w++;
                in_low = 1'b1;
                lo_len = 1;
            end else if (in_low) begin
                lo_len++;
            end
            if (int'(pos) != prev_pos) begin
                if (int'(pos) != prev_pos + sgn) bad_pos++;
                if (falls != SPU * iabs(int'(pos) - start)) bad_pos++;
            end
            prev_pos  = int'(pos);
            prev_step = step;
            if (poke && busy_cyc == 3) begin
                angle     = 5'd20;
                cmd_valid = 1'b1;
            end else begin
                cmd_valid = 1'b0;
            end
            if (done) got_done = 1'b1;
            else begin
                @(negedge clk);
                budget--;
            end
        end
        cmd_valid = 1'b0;

        check_val("done_seen", int'(got_done), 1);
        check_val("busy_cycles", busy_cyc, exp_busy);
        check_val("step_pulses", rises, iabs(tgt - start) * SPU);
        check_val("pulse_width_errs", bad_w, 0);
        check_val("dir_errs", bad_dir, 0);
        check_val("pos_track_errs", bad_pos, 0);
        check_val("pos_final", int'(pos), tgt);
        check_val("refl_out_final", int'(refl_out), r);
        check_val("limit_flag", int'(limit), exp_lim);
        @(negedge clk);
        check_val("done_one_cycle", int'(done), 0);
        check_val("rdy_after_done", int'(cmd_rdy), 1);
        m_pos  = tgt;
        m_refl = r;
    endtask

    initial begin
        int a, r, budget;
        bit poke;

        res       = 1'b0;
        cmd_valid = 1'b0;
        angle     = '0;
        refl      = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_step", int'(step), 0);
        check_val("rst_dir", int'(dir), 0);
        check_val("rst_refl_out", int'(refl_out), 0);
        check_val("rst_pos", int'(pos), 0);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_done", int'(done), 0);
        check_val("rst_limit", int'(limit), 0);
        check_val("rst_cmd_rdy", int'(cmd_rdy), 1);
        res = 1'b1;
        @(negedge clk);

        // Directed scenarios: up-move, down-move with reflector, zero move, ignored mid-move command.
        run_cmd(3, 0, 1'b0);
        run_cmd(1, 1, 1'b0);
        run_cmd(1, 1, 1'b0);
        run_cmd(10, 0, 1'b1);
`ifdef TRACKER_SOFT_LIMIT_EN
        run_cmd(31, 0, 1'b0);
        run_cmd(5, 0, 1'b0);
`else
        run_cmd(31, 0, 1'b0);
        run_cmd(0, 1, 1'b0);
`endif

        // Random command stream, some back-to-back, some with idle gaps and mid-move pokes.
        for (int i = 0; i < 20; i++) begin
            a    = int'($urandom_range(0, 31));
            r    = int'($urandom_range(0, 1));
            poke = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) repeat (int'($urandom_range(1, 3))) @(negedge clk);
            run_cmd(a, r, poke);
        end

        // Reset while a step pulse is high.
        a = (m_pos > 15) ? 0 : 25;
        angle     = 5'(a);
        refl      = 1'b1;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        budget = 0;
        while (!step && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        check_val("step_before_reset", int'(step), 1);
        res = 1'b0;
        @(negedge clk);
        check_val("midrst_step", int'(step), 0);
        check_val("midrst_pos", int'(pos), 0);
        check_val("midrst_busy", int'(busy), 0);
        check_val("midrst_cmd_rdy", int'(cmd_rdy), 1);
        res = 1'b1;
        m_pos  = 0;
        m_refl = 0;
        @(negedge clk);
        run_cmd(2, 1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
